pi_level_scheduler: RTL and testbench
=====================================

// Module: pi_level_scheduler
// PURPOSE
//  Schedules KL10 priority-interrupt levels 1-7 toward the CPU. Merges device and
//  program-set requests, masks them by enabled levels and by in-progress (PIH)
//  levels, and presents one level per req/ack handshake. Maintains PIR/PIH state.
//  Bit index == level. Index 0 is the highest priority; bit 0 is unused (forced 0).
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in WAIT without cpu_ack before the grant is dropped (PI_TIMEOUT_EN only)
// PORTS
//  clk       in   1      single clock, all state on posedge
//  rst_n     in   1      reset, synchronous, active-low
//  pi_on     in   1      system PI enable
//  cfg_we    in   1      write lvl_en from cfg_en this cycle
//  cfg_en    in   [0:7]  new level-enable mask
//  dev_req   in   [0:7]  level-sensitive device requests
//  sw_req    in   [0:7]  one-cycle pulses that set PIR bits
//  cpu_ack   in   1      CPU takes the presented level (pulse)
//  dismiss   in   1      CPU dismisses the highest in-progress level (pulse)
//  cpu_req   out  1      interrupt request to the CPU
//  cpu_lvl   out  [0:2]  level presented; stable while cpu_req=1
//  pir       out  [0:7]  program-request register
//  pih       out  [0:7]  in-progress register
//  lvl_en    out  [0:7]  level-enable register
//  ack_to    out  1      one-cycle pulse when a grant times out
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pir=pih=lvl_en=0, cpu_req=0, cpu_lvl=0, ack_to=0, state IDLE.
//    Reset in WAIT withdraws cpu_req on the next edge. It has priority over all inputs.
//  - raw  = (dev_req | pir) & lvl_en & 8'b0111_1111.
//  - hp   = highest (lowest-index) set bit of pih. elig = raw bits with index < hp.
//    If pih==0, elig = raw.
//  - States: IDLE, WAIT.
//    IDLE: if pi_on && |elig, then at the edge latch cpu_lvl = highest elig bit, set
//      cpu_req=1, go to WAIT. Latency: 1 cycle from the eligible input to cpu_req.
//    WAIT: cpu_lvl is frozen; a higher request arriving later does not preempt it.
//      cpu_ack: cpu_req=0, pih[cpu_lvl]<=1, pir[cpu_lvl]<=0, go to IDLE.
//      pi_on=0: cpu_req=0, go to IDLE; pih and pir are unchanged.
//    Back-to-back: the next cpu_req rises no earlier than 2 cycles after cpu_ack.
//  - dismiss clears bit hp of pih. It has no effect if pih==0. It is allowed in any state.
//  - Same-cycle events:
//    ack+dismiss: pih_next = (pih & ~dismiss_bit) | ack_bit.
//    sw_req and ack-clear on the same pir bit: the set wins.
//    cfg_we takes effect for elig on the next cycle.
//    cpu_ack outside WAIT is ignored.
//  - Device requests are not latched. A dev_req that drops in WAIT still completes the grant.
// CONFIGURATION
//  PI_TIMEOUT_EN defined:
//    - A $clog2(TIMEOUT_CYCLES)-bit counter clears on entry to WAIT and counts each WAIT cycle.
//    - When it reaches TIMEOUT_CYCLES-1 without cpu_ack: cpu_req=0, ack_to=1 for one cycle,
//      go to IDLE. pih and pir are unchanged, so the level re-arbitrates.
//    - cpu_ack on the timeout cycle wins, and ack_to stays 0.
//  PI_TIMEOUT_EN undefined: no counter, ack_to tied 0, WAIT holds until cpu_ack or pi_on=0.
// STRUCTURE
//  - pi_pkg:
//    pi_state_t enum {PI_IDLE, PI_WAIT}
//    pi_mask_t = bit [0:7]
//    pi_lvl_t = bit [0:2]
//    PI_LVL_MASK = 8'b0111_1111
//  - Instantiate the existing priority_encoder8 twice:
//    one on pih (gives hp and any_pih), one on elig (gives the grant level and any_elig).
//  - The elig mask is built combinationally from hp (index < hp).
// TESTING
//  1 lvl_en=FE, pi_on=1, dev_req=8'h10 (lvl3) -> cpu_req=1, cpu_lvl=3 next cycle.
//    ack -> pih=8'h10, cpu_req=0.
//  2 pih=8'h10, dev_req=8'h04 (lvl5) -> no cpu_req.
//    dev_req=8'h20 (lvl2) -> cpu_lvl=2. ack -> pih=8'h30.
//    dismiss -> pih=8'h10.
//  3 sw_req=8'h02 pulse with lvl_en=FE -> pir=8'h02, cpu_lvl=6.
//    ack -> pir=0, pih=8'h02.
//    sw_req=8'h02 on the ack cycle -> pir stays 8'h02.
//  4 WAIT on lvl4; raise lvl1 -> cpu_lvl stays 4 until ack.
//    2 cycles later -> cpu_req with cpu_lvl=1.
//  5 Same-cycle ack+dismiss with pih=8'h08, presented lvl1 -> pih=8'h40.
//    rst_n=0 mid-WAIT -> all outputs 0 next edge.
//  6 PI_TIMEOUT_EN, TIMEOUT_CYCLES=8: no ack -> ack_to pulse on the 8th WAIT cycle,
//    cpu_req falls, then reasserts with the same level.
//    Undefined: cpu_req is held for 100 cycles.

Source files
------------

// File: rtl/pi_level_scheduler_pkg.sv
// Shared types and helpers for the KL10 priority-interrupt level scheduler.
// Bit index equals level number; index 0 is the highest priority and is never used.
package pi_pkg;

  typedef enum logic [0:0] {PI_IDLE, PI_WAIT} pi_state_t;

  typedef bit [0:7] pi_mask_t;
  typedef bit [0:2] pi_lvl_t;

  localparam pi_mask_t PI_LVL_MASK = 8'b0111_1111;

  function automatic pi_mask_t lvl_onehot(pi_lvl_t lvl);
    pi_mask_t m;
    m      = '0;
    m[lvl] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pi_level_scheduler_if.sv
// CPU-side request/acknowledge handshake of the PI level scheduler.
// master = scheduler presenting levels, slave = CPU taking and dismissing them.
interface pi_level_scheduler_if;
  import pi_pkg::*;

  logic    cpu_req;
  pi_lvl_t cpu_lvl;
  logic    cpu_ack;
  logic    dismiss;

  modport master (output cpu_req, cpu_lvl, input cpu_ack, dismiss);
  modport slave  (input cpu_req, cpu_lvl, output cpu_ack, dismiss);

endinterface

// File: rtl/pi_level_scheduler_prio_enc.sv
// priority_encoder8: index of the lowest-numbered set bit (highest priority level).
// idx_o is 0 when no bit is set; any_o qualifies it.
module priority_encoder8 (
  input  logic [0:7] in_i,
  output logic [0:2] idx_o,
  output logic       any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |in_i;
    for (int i = 7; i >= 0; i--) begin
      if (in_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/pi_level_scheduler.sv
// Priority-interrupt level scheduler: merges PIR and device requests, masks by enable and PIH.
// Optional grant timeout is built when PI_TIMEOUT_EN is defined.
//
//  state   | meaning
//  PI_IDLE | no level presented; arbitrate eligible levels each cycle
//  PI_WAIT | cpu_lvl frozen and cpu_req high until ack, pi_on drop or timeout
module pi_level_scheduler
  import pi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pi_on,
  input  logic                        cfg_we,
  input  pi_mask_t                    cfg_en,
  input  pi_mask_t                    dev_req,
  input  pi_mask_t                    sw_req,
  pi_level_scheduler_if.master        cpu,
  output pi_mask_t                    pir,
  output pi_mask_t                    pih,
  output pi_mask_t                    lvl_en,
  output logic                        ack_to
);

  pi_state_t state_q, state_d;
  pi_lvl_t   lvl_q, lvl_d;
  pi_mask_t  pir_q, pir_d;
  pi_mask_t  pih_q, pih_d;
  pi_mask_t  lvl_en_q, lvl_en_d;

  logic [0:2] hp;
  logic       any_pih;
  logic [0:2] grant_lvl;
  logic       any_elig;
  pi_mask_t   raw, below_hp, elig;
  pi_mask_t   ack_bit, dis_bit;
  logic       ack_take;
  logic       timeout_hit;

  priority_encoder8 u_pih_enc (
    .in_i  (pih_q),
    .idx_o (hp),
    .any_o (any_pih)
  );

  // Only levels strictly above the highest in-progress one may interrupt it.
  always_comb begin
    below_hp = '0;
    for (int i = 0; i < 8; i++) begin
      below_hp[i] = !any_pih || (i < int'(hp));
    end
  end

  assign raw  = (dev_req | pir_q) & lvl_en_q & PI_LVL_MASK;
  assign elig = raw & below_hp;

  priority_encoder8 u_elig_enc (
    .in_i  (elig),
    .idx_o (grant_lvl),
    .any_o (any_elig)
  );

  assign ack_take = (state_q == PI_WAIT) && cpu.cpu_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PI_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PI_IDLE: if (pi_on && any_elig) state_d = PI_WAIT;
      PI_WAIT: if (ack_take || !pi_on || timeout_hit) state_d = PI_IDLE;
      default: state_d = PI_IDLE;
    endcase
  end

  always_comb begin
    cpu.cpu_req = (state_q == PI_WAIT);
    cpu.cpu_lvl = lvl_q;
  end

  // Ack sets PIH and clears PIR for the presented level; a same-cycle sw_req set wins.
  always_comb begin
    ack_bit  = ack_take ? lvl_onehot(lvl_q) : '0;
    dis_bit  = (cpu.dismiss && any_pih) ? lvl_onehot(hp) : '0;
    pih_d    = ((pih_q & ~dis_bit) | ack_bit) & PI_LVL_MASK;
    pir_d    = ((pir_q & ~ack_bit) | sw_req) & PI_LVL_MASK;
    lvl_en_d = cfg_we ? cfg_en : lvl_en_q;
    lvl_d    = (state_q == PI_IDLE && state_d == PI_WAIT) ? grant_lvl : lvl_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q    <= '0;
      pir_q    <= '0;
      pih_q    <= '0;
      lvl_en_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      pir_q    <= pir_d;
      pih_q    <= pih_d;
      lvl_en_q <= lvl_en_d;
    end
  end

`ifdef PI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_to_q, ack_to_d;

  // Held at zero outside WAIT so every grant starts a fresh count.
  assign cnt_d       = (state_q == PI_WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout_hit = (state_q == PI_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ack_to_d    = timeout_hit && !ack_take;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ack_to_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ack_to_q <= ack_to_d;
    end
  end

  assign ack_to = ack_to_q;
`else
  assign timeout_hit = 1'b0;
  assign ack_to      = 1'b0;
`endif

  assign pir    = pir_q;
  assign pih    = pih_q;
  assign lvl_en = lvl_en_q;

endmodule

// File: tb/tb_pi_level_scheduler.sv
// Bench for pi_level_scheduler: register checks plus a grant-level scoreboard.
// Covers the grant timeout when PI_TIMEOUT_EN is defined, otherwise the indefinite hold.
module tb_pi_level_scheduler;
  import pi_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     pi_on;
  logic     cfg_we;
  pi_mask_t cfg_en;
  pi_mask_t dev_req;
  pi_mask_t sw_req;
  pi_mask_t pir, pih, lvl_en;
  logic     ack_to;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_req;

  pi_level_scheduler_if cpu_if ();

`ifdef PI_TIMEOUT_EN
  pi_level_scheduler #(.TIMEOUT_CYCLES(8)) dut (
`else
  pi_level_scheduler dut (
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .pi_on   (pi_on),
    .cfg_we  (cfg_we),
    .cfg_en  (cfg_en),
    .dev_req (dev_req),
    .sw_req  (sw_req),
    .cpu     (cpu_if.master),
    .pir     (pir),
    .pih     (pih),
    .lvl_en  (lvl_en),
    .ack_to  (ack_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every rising cpu_req must match the oldest expected grant level.
  always @(negedge clk) begin
    if (cpu_if.cpu_req && !prev_req) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(cpu_if.cpu_lvl), 32'hFF);
      else                   chk("sb_grant_lvl", 32'(cpu_if.cpu_lvl), 32'(exp_q.pop_front()));
    end
    prev_req = cpu_if.cpu_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_req       = 1'b0;
    rst_n          = 1'b0;
    pi_on          = 1'b0;
    cfg_we         = 1'b0;
    cfg_en         = '0;
    dev_req        = '0;
    sw_req         = '0;
    cpu_if.cpu_ack = 1'b0;
    cpu_if.dismiss = 1'b0;
    tick(2);
    chk("rst_cpu_req", 32'(cpu_if.cpu_req), 0);
    chk("rst_cpu_lvl", 32'(cpu_if.cpu_lvl), 0);
    chk("rst_pir",     32'(pir), 0);
    chk("rst_pih",     32'(pih), 0);
    chk("rst_lvl_en",  32'(lvl_en), 0);
    chk("rst_ack_to",  32'(ack_to), 0);

    rst_n = 1'b1; pi_on = 1'b1; cfg_we = 1'b1; cfg_en = 8'hFE;
    tick(); cfg_we = 1'b0;
    chk("cfg_lvl_en", 32'(lvl_en), 32'hFE);

    // Device request on level 3, then ack.
    dev_req = 8'h10; exp_q.push_back(3);
    tick();
    chk("t1_req", 32'(cpu_if.cpu_req), 1);
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0; dev_req = '0;
    chk("t1_pih", 32'(pih), 32'h10);
    chk("t1_req_drop", 32'(cpu_if.cpu_req), 0);

    // Lower level blocked by PIH, higher one preempts, then dismiss.
    dev_req = 8'h04;
    tick(2);
    chk("t2_blocked", 32'(cpu_if.cpu_req), 0);
    dev_req = 8'h24; exp_q.push_back(2);
    tick();
    chk("t2_lvl", 32'(cpu_if.cpu_lvl), 2);
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0; dev_req = '0;
    chk("t2_pih_ack", 32'(pih), 32'h30);
    cpu_if.dismiss = 1'b1; tick(); cpu_if.dismiss = 1'b0;
    chk("t2_pih_dismiss", 32'(pih), 32'h10);
    cpu_if.dismiss = 1'b1; tick(); cpu_if.dismiss = 1'b0;
    chk("t2_pih_empty", 32'(pih), 0);

    // Program request on level 6.
    sw_req = 8'h02; exp_q.push_back(6);
    tick(); sw_req = '0;
    chk("t3_pir_set", 32'(pir), 32'h02);
    tick();
    chk("t3_lvl", 32'(cpu_if.cpu_lvl), 6);
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0;
    chk("t3_pir_clr", 32'(pir), 0);
    chk("t3_pih", 32'(pih), 32'h02);
    cpu_if.dismiss = 1'b1; tick(); cpu_if.dismiss = 1'b0;
    sw_req = 8'h02; exp_q.push_back(6);
    tick(); sw_req = '0;
    tick();
    chk("t3_req2", 32'(cpu_if.cpu_req), 1);
    cpu_if.cpu_ack = 1'b1; sw_req = 8'h02;
    tick(); cpu_if.cpu_ack = 1'b0; sw_req = '0;
    chk("t3_pir_set_wins", 32'(pir), 32'h02);
    chk("t3_pih2", 32'(pih), 32'h02);
    cpu_if.dismiss = 1'b1; exp_q.push_back(6);
    tick(); cpu_if.dismiss = 1'b0;
    tick();
    chk("t3_rearb_req", 32'(cpu_if.cpu_req), 1);
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0;
    chk("t3_pir_final", 32'(pir), 0);
    cpu_if.dismiss = 1'b1; tick(); cpu_if.dismiss = 1'b0;
    chk("t3_pih_final", 32'(pih), 0);

    // WAIT on level 4 is not preempted by level 1.
    dev_req = 8'h08; exp_q.push_back(4);
    tick();
    dev_req = 8'h48;
    tick(3);
    chk("t4_frozen_lvl", 32'(cpu_if.cpu_lvl), 4);
    chk("t4_frozen_req", 32'(cpu_if.cpu_req), 1);
    exp_q.push_back(1);
    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0;
    chk("t4_gap", 32'(cpu_if.cpu_req), 0);
    tick();
    chk("t4_next_lvl", 32'(cpu_if.cpu_lvl), 1);

    // Same-cycle ack and dismiss.
    dev_req = '0; cpu_if.cpu_ack = 1'b1; cpu_if.dismiss = 1'b1;
    tick(); cpu_if.cpu_ack = 1'b0; cpu_if.dismiss = 1'b0;
    chk("t5_ack_dismiss", 32'(pih), 32'h40);
    cpu_if.dismiss = 1'b1; tick(); cpu_if.dismiss = 1'b0;

    // Reset in the middle of WAIT.
    dev_req = 8'h20; exp_q.push_back(2);
    tick();
    chk("t5_wait", 32'(cpu_if.cpu_req), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_req", 32'(cpu_if.cpu_req), 0);
    chk("t5_rst_lvl", 32'(cpu_if.cpu_lvl), 0);
    chk("t5_rst_en",  32'(lvl_en), 0);
    tick(2);
    chk("t5_disabled", 32'(cpu_if.cpu_req), 0);

    // pi_on drop withdraws the grant without touching PIH.
    cfg_we = 1'b1; cfg_en = 8'hFE; exp_q.push_back(2);
    tick(); cfg_we = 1'b0;
    tick();
    chk("t5_regrant", 32'(cpu_if.cpu_req), 1);
    pi_on = 1'b0; tick();
    chk("t5_pioff_req", 32'(cpu_if.cpu_req), 0);
    chk("t5_pioff_pih", 32'(pih), 0);
    pi_on = 1'b1; exp_q.push_back(2);
    tick();

`ifdef PI_TIMEOUT_EN
    tick(7);
    chk("t6_before_to", 32'(ack_to), 0);
    chk("t6_req_held", 32'(cpu_if.cpu_req), 1);
    exp_q.push_back(2);
    tick();
    chk("t6_ack_to", 32'(ack_to), 1);
    chk("t6_req_drop", 32'(cpu_if.cpu_req), 0);
    tick();
    chk("t6_ack_to_pulse", 32'(ack_to), 0);
    chk("t6_rereq_lvl", 32'(cpu_if.cpu_lvl), 2);
`else
    tick(100);
    chk("t6_hold_req", 32'(cpu_if.cpu_req), 1);
    chk("t6_hold_lvl", 32'(cpu_if.cpu_lvl), 2);
    chk("t6_no_ack_to", 32'(ack_to), 0);
`endif

    cpu_if.cpu_ack = 1'b1; tick(); cpu_if.cpu_ack = 1'b0; dev_req = '0;
    chk("end_pih", 32'(pih), 32'h20);
    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
